// File: rtl/dm_axi_master_if.sv
// AXI4-lite style single-beat bus between the data-memory master and the interconnect.
interface dm_axi_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   ARADDR;
    logic                ARVALID;
    logic                ARREADY;
    logic [DATA_W-1:0]   RDATA;
    logic [1:0]          RRESP;
    logic                RVALID;
    logic                RREADY;
    logic [ADDR_W-1:0]   AWADDR;
    logic                AWVALID;
    logic                AWREADY;
    logic [DATA_W-1:0]   WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic                WVALID;
    logic                WREADY;
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;

    modport master (
        output ARADDR, ARVALID,
        input  ARREADY,
        input  RDATA, RRESP, RVALID,
        output RREADY,
        output AWADDR, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WVALID,
        input  WREADY,
        input  BRESP, BVALID,
        output BREADY
    );

    modport slave (
        input  ARADDR, ARVALID,
        output ARREADY,
        output RDATA, RRESP, RVALID,
        input  RREADY,
        input  AWADDR, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WVALID,
        output WREADY,
        output BRESP, BVALID,
        input  BREADY
    );
endinterface

// File: rtl/dm_axi_master.sv
// MEM-stage load/store to single-beat AXI master; stalls the pipeline until done.
// Optional response watchdog: define DM_AXI_TIMEOUT_EN.
module dm_axi_master #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    output logic [DATA_W-1:0] rdata,
    output logic              stall,
    output logic              bus_err,
    dm_axi_master_if.master   axi
);
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [2:0] {
        IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_aw_done;
    logic              r_w_done;
    logic [DATA_W-1:0] r_rdata;
    logic              r_bus_err;

    logic w_wr_req;
    logic w_rd_req;
    logic w_ar_hs;
    logic w_r_hs;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_b_hs;
    logic w_aw_ok;
    logic w_w_ok;
    logic w_timeout;
    logic w_idle_rdy;

    // A store request without the STORE opcode is not a request at all.
    assign w_wr_req = mem_write && (opcode == OP_STORE);
    assign w_rd_req = mem_read;

    assign w_ar_hs = axi.ARVALID && axi.ARREADY;
    assign w_r_hs  = axi.RVALID  && axi.RREADY;
    assign w_aw_hs = axi.AWVALID && axi.AWREADY;
    assign w_w_hs  = axi.WVALID  && axi.WREADY;
    assign w_b_hs  = axi.BVALID  && axi.BREADY;

    assign w_aw_ok = r_aw_done || w_aw_hs;
    assign w_w_ok  = r_w_done  || w_w_hs;

`ifdef DM_AXI_TIMEOUT_EN
    localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W   = (CNT_RAW > 8) ? CNT_RAW : 8;

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (r_state == RD_DATA || r_state == WR_RESP) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_idle_rdy = 1'b1;
`else
    logic w_unused;

    assign w_timeout  = 1'b0;
    assign w_idle_rdy = 1'b0;
    assign w_unused   = (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_wr_req) begin
                    w_next = WR_REQ;
                end else if (w_rd_req) begin
                    w_next = RD_ADDR;
                end
            end
            RD_ADDR: begin
                if (w_ar_hs) w_next = RD_DATA;
            end
            RD_DATA: begin
                if (w_r_hs || w_timeout) w_next = DONE;
            end
            WR_REQ: begin
                if (w_aw_ok && w_w_ok) w_next = WR_RESP;
            end
            WR_RESP: begin
                if (w_b_hs || w_timeout) w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // In IDLE the R/B channels only open to drain late beats after a timeout.
    always_comb begin
        axi.ARVALID = (r_state == RD_ADDR);
        axi.RREADY  = (r_state == RD_DATA) ||
                      (r_state == IDLE && w_idle_rdy && rst);
        axi.AWVALID = (r_state == WR_REQ) && !r_aw_done;
        axi.WVALID  = (r_state == WR_REQ) && !r_w_done;
        axi.BREADY  = (r_state == WR_RESP) ||
                      (r_state == IDLE && w_idle_rdy && rst);
        stall       = rst && (w_wr_req || w_rd_req) &&
                      (r_state != DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else if (r_state == WR_REQ) begin
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs)  r_w_done  <= 1'b1;
        end else begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata   <= '0;
            r_bus_err <= 1'b0;
        end else begin
            if (r_state == RD_DATA) begin
                if (w_r_hs) begin
                    r_rdata <= axi.RDATA;
                    if (axi.RRESP != 2'b00) r_bus_err <= 1'b1;
                end else if (w_timeout) begin
                    r_rdata   <= 32'hDEAD_BEEF;
                    r_bus_err <= 1'b1;
                end
            end
            if (r_state == WR_RESP) begin
                if (w_b_hs) begin
                    if (axi.BRESP != 2'b00) r_bus_err <= 1'b1;
                end else if (w_timeout) begin
                    r_bus_err <= 1'b1;
                end
            end
        end
    end

    assign rdata   = r_rdata;
    assign bus_err = r_bus_err;

    assign axi.ARADDR = {addr[ADDR_W-1:2], 2'b00};
    assign axi.AWADDR = {addr[ADDR_W-1:2], 2'b00};
    assign axi.WDATA  = wdata << {addr[1:0], 3'b000};

    always_comb begin
        axi.WSTRB = 4'b0000;
        unique case (funct3)
            3'b000:  axi.WSTRB = 4'b0001 << addr[1:0];
            3'b001:  axi.WSTRB = 4'b0011 << {addr[1], 1'b0};
            3'b010:  axi.WSTRB = 4'b1111;
            default: axi.WSTRB = 4'b0000;
        endcase
    end
endmodule

// File: tb/tb_dm_axi_master.sv
// Directed bench for dm_axi_master with an AR/AW/W/R scoreboard.
module tb_dm_axi_master;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_LD = 7'b0000011;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic [31:0] rdata;
    logic        stall;
    logic        bus_err;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] q_ar[$];
    logic [31:0] q_aw[$];
    logic [31:0] q_wd[$];
    logic [3:0]  q_ws[$];
    logic [31:0] q_rd[$];

    dm_axi_master_if #(.ADDR_W(32), .DATA_W(32)) axi ();

    dm_axi_master #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .addr      (addr),
        .wdata     (wdata),
        .opcode    (opcode),
        .funct3    (funct3),
        .rdata     (rdata),
        .stall     (stall),
        .bus_err   (bus_err),
        .axi       (axi)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [2:0] f3,
                          input int lim, output int nst);
        tick();
        mem_read  = !wr;
        mem_write = wr;
        addr      = a;
        wdata     = d;
        funct3    = f3;
        opcode    = wr ? OP_ST : OP_LD;
        nst = 0;
        @(negedge clk);
        while (stall && nst < lim) begin
            nst++;
            @(negedge clk);
        end
    endtask

    task automatic end_op();
        tick();
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (axi.ARVALID && axi.ARREADY) begin
                check("ar_pending", 32'(q_ar.size() != 0), 32'd1);
                if (q_ar.size() != 0)
                    check("araddr", axi.ARADDR, q_ar.pop_front());
            end
            if (axi.AWVALID && axi.AWREADY) begin
                check("aw_pending", 32'(q_aw.size() != 0), 32'd1);
                if (q_aw.size() != 0)
                    check("awaddr", axi.AWADDR, q_aw.pop_front());
            end
            if (axi.WVALID && axi.WREADY) begin
                check("w_pending", 32'(q_wd.size() != 0), 32'd1);
                if (q_wd.size() != 0) begin
                    check("wdata", axi.WDATA, q_wd.pop_front());
                    check("wstrb", 32'(axi.WSTRB), 32'(q_ws.pop_front()));
                end
            end
        end
    end

    int n;
    int aw_n;
    int w_n;
    logic early;

    initial begin
        axi.ARREADY = 1'b1;
        axi.RVALID  = 1'b1;
        axi.RDATA   = '0;
        axi.RRESP   = 2'b00;
        axi.AWREADY = 1'b1;
        axi.WREADY  = 1'b1;
        axi.BVALID  = 1'b1;
        axi.BRESP   = 2'b00;
        mem_read    = 1'b1;
        #12;
        check("rst_arvalid", 32'(axi.ARVALID), 32'd0);
        check("rst_rready", 32'(axi.RREADY), 32'd0);
        check("rst_awvalid", 32'(axi.AWVALID), 32'd0);
        check("rst_wvalid", 32'(axi.WVALID), 32'd0);
        check("rst_bready", 32'(axi.BREADY), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_buserr", 32'(bus_err), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        mem_read = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        axi.RDATA = 32'h1234_5678;
        q_ar.push_back(32'h1004);
        q_rd.push_back(32'h1234_5678);
        run_op(1'b0, 32'h1004, 32'h0, 3'b010, 20, n);
        check("lw_stall", 32'(n), 32'd3);
        check("lw_rdata", rdata, q_rd.pop_front());
        end_op();

        q_aw.push_back(32'h2000);
        q_wd.push_back(32'hAB00_0000);
        q_ws.push_back(4'b1000);
        run_op(1'b1, 32'h2003, 32'hAB, 3'b000, 20, n);
        check("sb_stall", 32'(n), 32'd3);
        end_op();
        check("rdata_hold", rdata, 32'h1234_5678);

        q_aw.push_back(32'h2000);
        q_wd.push_back(32'hBEEF_0000);
        q_ws.push_back(4'b1100);
        run_op(1'b1, 32'h2002, 32'hBEEF, 3'b001, 20, n);
        check("sh_stall", 32'(n), 32'd3);
        end_op();

        q_aw.push_back(32'h6000);
        q_wd.push_back(32'h1234_5677);
        q_ws.push_back(4'b0001);
        run_op(1'b1, 32'h6000, 32'h1234_5677, 3'b000, 20, n);
        end_op();

        q_aw.push_back(32'h5000);
        q_wd.push_back(32'h0000_FF00);
        q_ws.push_back(4'b0000);
        run_op(1'b1, 32'h5001, 32'hFF, 3'b011, 20, n);
        check("f3bad_stall", 32'(n), 32'd3);
        end_op();
        check("buserr_clean", 32'(bus_err), 32'd0);

        axi.AWREADY = 1'b0;
        axi.BVALID  = 1'b0;
        q_aw.push_back(32'h3008);
        q_wd.push_back(32'hCAFE_F00D);
        q_ws.push_back(4'b1111);
        mem_write = 1'b1;
        opcode    = OP_ST;
        funct3    = 3'b010;
        addr      = 32'h3008;
        wdata     = 32'hCAFE_F00D;
        @(negedge clk);
        check("sw_idle_stall", 32'(stall), 32'd1);
        aw_n = 0;
        w_n = 0;
        early = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 3) axi.AWREADY = 1'b1;
            @(negedge clk);
            if (axi.AWVALID) aw_n++;
            if (axi.WVALID) w_n++;
            early = early | axi.BREADY;
        end
        tick();
        @(negedge clk);
        check("sw_aw_cycles", 32'(aw_n), 32'd4);
        check("sw_w_cycles", 32'(w_n), 32'd1);
        check("sw_bready_early", 32'(early), 32'd0);
        check("sw_bready", 32'(axi.BREADY), 32'd1);
        check("sw_aw_drop", 32'(axi.AWVALID), 32'd0);
        check("sw_resp_stall", 32'(stall), 32'd1);
        tick();
        axi.BVALID = 1'b1;
        @(negedge clk);
        check("sw_bvalid_stall", 32'(stall), 32'd1);
        tick();
        @(negedge clk);
        check("sw_done_stall", 32'(stall), 32'd0);
        end_op();

        axi.RDATA = 32'h0BAD_F00D;
        axi.RRESP = 2'b10;
        q_ar.push_back(32'h4000);
        q_rd.push_back(32'h0BAD_F00D);
        run_op(1'b0, 32'h4000, 32'h0, 3'b010, 20, n);
        check("rerr_stall", 32'(n), 32'd3);
        check("rerr_rdata", rdata, q_rd.pop_front());
        check("rerr_buserr", 32'(bus_err), 32'd1);
        end_op();
        axi.RRESP = 2'b00;

        q_aw.push_back(32'h4004);
        q_wd.push_back(32'h1122_3344);
        q_ws.push_back(4'b1111);
        run_op(1'b1, 32'h4004, 32'h1122_3344, 3'b010, 20, n);
        end_op();
        check("sticky_wr", 32'(bus_err), 32'd1);

        axi.RDATA = 32'h55AA_55AA;
        q_ar.push_back(32'h4004);
        q_rd.push_back(32'h55AA_55AA);
        run_op(1'b0, 32'h4007, 32'h0, 3'b000, 20, n);
        check("lb_rdata", rdata, q_rd.pop_front());
        check("sticky_rd", 32'(bus_err), 32'd1);
        end_op();

        tick();
        mem_write = 1'b1;
        opcode    = 7'b0110011;
        @(negedge clk);
        check("nostore_stall", 32'(stall), 32'd0);
        tick();
        @(negedge clk);
        check("nostore_awvalid", 32'(axi.AWVALID), 32'd0);
        check("nostore_stall2", 32'(stall), 32'd0);
        end_op();

        axi.RVALID = 1'b0;
        q_ar.push_back(32'h7000);
`ifdef DM_AXI_TIMEOUT_EN
        q_rd.push_back(32'hDEAD_BEEF);
        run_op(1'b0, 32'h7000, 32'h0, 3'b010, 40, n);
        check("to_stall", 32'(n), 32'd10);
        check("to_rdata", rdata, q_rd.pop_front());
        check("to_buserr", 32'(bus_err), 32'd1);
        end_op();
        axi.RVALID = 1'b1;
        @(negedge clk);
        check("to_late_rready", 32'(axi.RREADY), 32'd1);
`else
        run_op(1'b0, 32'h7000, 32'h0, 3'b010, 30, n);
        check("hang_stall_cnt", 32'(n), 32'd30);
        check("hang_stall", 32'(stall), 32'd1);
        rst = 1'b0;
        mem_read = 1'b0;
        axi.RVALID = 1'b1;
        @(negedge clk);
        rst = 1'b1;
`endif

        axi.AWREADY = 1'b0;
        axi.WREADY  = 1'b0;
        tick();
        mem_write = 1'b1;
        opcode    = OP_ST;
        funct3    = 3'b010;
        addr      = 32'h8000;
        wdata     = 32'h1;
        for (int i = 0; i < 5 && !axi.AWVALID; i++) @(negedge clk);
        check("rm_awvalid_pre", 32'(axi.AWVALID), 32'd1);
        check("rm_stall_pre", 32'(stall), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("rm_awvalid", 32'(axi.AWVALID), 32'd0);
        check("rm_wvalid", 32'(axi.WVALID), 32'd0);
        check("rm_stall", 32'(stall), 32'd0);
        check("rm_buserr", 32'(bus_err), 32'd0);
        check("rm_rdata", rdata, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        mem_write = 1'b0;
        axi.AWREADY = 1'b1;
        axi.WREADY  = 1'b1;
        @(negedge clk);
        check("rm_idle_aw", 32'(axi.AWVALID), 32'd0);
        check("rm_idle_stall", 32'(stall), 32'd0);

        axi.RDATA = 32'h600D_F00D;
        q_ar.push_back(32'h9000);
        q_rd.push_back(32'h600D_F00D);
        run_op(1'b0, 32'h9000, 32'h0, 3'b010, 20, n);
        check("post_rst_stall", 32'(n), 32'd3);
        check("post_rst_rdata", rdata, q_rd.pop_front());
        check("post_rst_err", 32'(bus_err), 32'd0);
        end_op();

        repeat (2) @(negedge clk);
        check("q_ar_empty", 32'(q_ar.size()), 32'd0);
        check("q_aw_empty", 32'(q_aw.size()), 32'd0);
        check("q_w_empty", 32'(q_wd.size()), 32'd0);
        check("q_rd_empty", 32'(q_rd.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
